// File: rtl/cordic_tanh_iter.sv
// Iterative tanh(x): hyperbolic CORDIC (rotation mode) yields sinh/cosh of the
// clamped |x|, then a restoring divider forms sinh/cosh one bit per cycle.
// The sign is re-applied only after division, so results are odd-symmetric.
module cordic_tanh_iter #(
  parameter int IW   = 16,
  parameter int IF   = 8,
  parameter int OW   = 8,
  parameter int ITER = 12,
  parameter int GW   = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] tanh,
  output logic          clip
);

  localparam int WF = IF + OW + GW;          // datapath fraction bits
  localparam int DW = WF + 4;                // headroom for |x_r|,|y_r| < 8
  localparam int R  = ITER + ((ITER >= 4) ? 1 : 0) + ((ITER >= 13) ? 1 : 0);
  localparam int FB = 60;                    // precision of elaboration-time math

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ROT  = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [IW:0] ONE_IN = (IW+1)'(1) << IF;

  // atanh(2^-i) at FB fraction bits via the odd power series
  function automatic logic [127:0] atanh_fx(input int i);
    logic [127:0] acc;
    int e;
    acc = '0;
    for (int k = 0; k < 32; k++) begin
      e = i * (2 * k + 1);
      if (e <= FB) acc = acc + ((128'd1 << (FB - e)) / 128'(2 * k + 1));
    end
    return acc;
  endfunction

  // atanh(2^-i) rounded to WF fraction bits
  function automatic logic [DW-1:0] atanh_c(input int i);
    logic [127:0] v;
    v = (atanh_fx(i) + (128'd1 << (FB - WF - 1))) >> (FB - WF);
    return v[DW-1:0];
  endfunction

  // packed table, entry i at [i*DW +: DW]; 32 entries so any 5-bit shift indexes it
  function automatic logic [32*DW-1:0] atab_build();
    logic [32*DW-1:0] t;
    t = '0;
    for (int i = 1; i < 32; i++) t[i*DW +: DW] = atanh_c(i);
    return t;
  endfunction

  // 1/K_h over the exact iteration sequence (repeats included), WF fraction bits.
  // K_h^2 = prod(1 - 4^-i); take an integer square root, then invert.
  function automatic logic [DW-1:0] inv_gain();
    logic [127:0] p, v, r, t, one;
    one = 128'd1 << FB;
    p   = one;
    for (int i = 1; i <= ITER; i++) begin
      p = (p * (one - (128'd1 << (FB - 2 * i)))) >> FB;
      if (i == 4 || i == 13) p = (p * (one - (128'd1 << (FB - 2 * i)))) >> FB;
    end
    v = p << FB;
    r = '0;
    for (int b = 63; b >= 0; b--) begin
      t = r | (128'd1 << b);
      if (t * t <= v) r = t;
    end
    v = ((128'd1 << (FB + WF)) + (r >> 1)) / r;
    return v[DW-1:0];
  endfunction

  localparam logic [32*DW-1:0]    ATAB  = atab_build();
  localparam logic signed [DW-1:0] INV_K = inv_gain();
  localparam logic signed [DW-1:0] A1    = atanh_c(1);

  logic [1:0]           state;
  logic signed [DW-1:0] x_r, y_r, z_r;
  logic [4:0]           sh, cnt, dcnt;
  logic                 rep, sgn, clip_p;
  logic [OW-3:0]        q;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // sample conditioning: |x| with one extra bit so -2^(IW-1) is representable
  logic [IW:0]   ax, zmag;
  logic          clip_in;
  logic [DW-1:0] z0;
  always_comb begin
    ax      = in[IW-1] ? -{in[IW-1], in} : {in[IW-1], in};
    clip_in = (ax > ONE_IN);
    zmag    = clip_in ? ONE_IN : ax;
    z0      = DW'(zmag) << (WF - IF);
  end

  // one hyperbolic rotation using the current shift
  logic                 dpos, rep_now;
  logic signed [DW-1:0] xs, ys, at, xn, yn, zn;
  always_comb begin
    dpos    = ~z_r[DW-1];
    xs      = x_r >>> sh;
    ys      = y_r >>> sh;
    at      = $signed(ATAB[int'(sh)*DW +: DW]);
    xn      = dpos ? x_r + ys : x_r - ys;
    yn      = dpos ? y_r + xs : y_r - xs;
    zn      = dpos ? z_r - at : z_r + at;
    rep_now = ((sh == 5'd4) || (sh == 5'd13)) && !rep;
  end

  // one restoring-division step: y_r is the remainder, x_r the divisor
  logic [DW:0]   r2;
  logic [DW-1:0] rs;
  logic          qb;
  logic [OW-2:0] mag;
  always_comb begin
    r2  = {y_r, 1'b0};
    qb  = (r2 >= {1'b0, x_r});
    rs  = r2[DW-1:0] - x_r;
    mag = {q, qb};
  end

  // control FSM and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      x_r    <= '0;
      y_r    <= '0;
      z_r    <= '0;
      sh     <= '0;
      cnt    <= '0;
      dcnt   <= '0;
      rep    <= 1'b0;
      sgn    <= 1'b0;
      clip_p <= 1'b0;
      q      <= '0;
      tanh   <= '0;
      clip   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          // z starts non-negative, so iteration i=1 always has d=+1; it is
          // folded into the load: x=1/K, y=(1/K)/2, z=z0-atanh(1/2)
          sgn    <= in[IW-1];
          clip_p <= clip_in;
          x_r    <= INV_K;
          y_r    <= INV_K >>> 1;
          z_r    <= z0 - A1;
          sh     <= 5'd2;
          rep    <= 1'b0;
          cnt    <= '0;
          state  <= ROT;
        end
        ROT: begin
          x_r <= xn;
          z_r <= zn;
          cnt <= cnt + 5'd1;
          if (rep_now) rep <= 1'b1;
          else begin
            sh  <= sh + 5'd1;
            rep <= 1'b0;
          end
          if (cnt == 5'(R - 2)) begin
            // sinh(|x|) >= 0; clamp residual rounding below zero
            y_r   <= yn[DW-1] ? '0 : yn;
            q     <= '0;
            dcnt  <= '0;
            state <= DIV;
          end else begin
            y_r <= yn;
          end
        end
        DIV: begin
          y_r  <= qb ? $signed(rs) : $signed(r2[DW-1:0]);
          q    <= mag[OW-3:0];
          dcnt <= dcnt + 5'd1;
          if (dcnt == 5'(OW - 2)) begin
            // y<x keeps mag within 2^(OW-1)-1, so no extra saturation needed
            tanh  <= sgn ? -{1'b0, mag} : {1'b0, mag};
            clip  <= clip_p;
            state <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_tanh_iter.sv
// Directed bench for cordic_tanh_iter at default parameters.
module tb_cordic_tanh_iter;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, out_valid, out_ready, clip;
  logic [15:0] in;
  logic [7:0]  tanh;
  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  cordic_tanh_iter dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in(in),
    .out_valid(out_valid), .out_ready(out_ready), .tanh(tanh), .clip(clip)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_near(input string tag, input int obs, input int exp);
    ntests++;
    assert ((obs - exp) <= 1 && (exp - obs) <= 1) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d +/-1", tag, obs, exp);
    end
  endtask

  // one transaction with out_ready=1; returns signed tanh, clip, and edges to out_valid
  task automatic run(input logic [15:0] v, output int t, output int c, output int lat);
    in = v;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    t = int'($signed(tanh));
    c = int'(clip);
    @(posedge clk); #1;
  endtask

  int t, c, lat, tp5, tp1, t0, c0, seen;

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_tanh", int'(tanh), 0);
    chk("rst_clip", int'(clip), 0);

    run(16'h0000, t, c, lat);
    chk("zero_tanh", t, 0); chk("zero_clip", c, 0); chk("zero_lat", lat, 19);

    run(16'h0080, tp5, c, lat);
    chk_near("p05_tanh", tp5, 59); chk("p05_clip", c, 0); chk("p05_lat", lat, 19);
    run(16'hFF80, t, c, lat);
    chk("m05_odd", t, -tp5); chk("m05_clip", c, 0); chk("m05_lat", lat, 19);

    run(16'h0300, tp1, c, lat);
    chk_near("p3_tanh", tp1, 97); chk("p3_clip", c, 1);
    run(16'h8000, t, c, lat);
    chk_near("min_tanh", t, -97); chk("min_clip", c, 1); chk("min_odd", t, -tp1);
    chk("min_lat", lat, 19);

    run(16'h0100, t, c, lat);
    chk_near("one_tanh", t, 97); chk("one_clip", c, 0);
    run(16'h0101, t, c, lat);
    chk("above_one_clip", c, 1);
    run(16'h7FFF, t, c, lat);
    chk_near("max_tanh", t, 97); chk("max_clip", c, 1);

    run(16'h0040, t0, c, lat);
    chk_near("q25_tanh", t0, 31);
    run(16'hFFC0, t, c, lat);
    chk("mq25_odd", t, -t0);
    run(16'h00C0, t, c, lat);
    chk_near("q75_tanh", t, 81);
    run(16'h0020, t, c, lat);
    chk_near("q125_tanh", t, 15);
    run(16'h0001, t, c, lat);
    chk_near("lsb_tanh", t, 0); chk("lsb_clip", c, 0);

    // backpressure: result held, new samples ignored
    out_ready = 1'b0;
    in = 16'h0080; in_valid = 1'b1;
    @(posedge clk); #1;
    in = 16'h0300;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("stall_lat", lat, 19);
    t0 = int'($signed(tanh)); c0 = int'(clip);
    chk("stall_tanh", t0, tp5);
    for (int k = 0; k < 10; k++) begin
      in_valid = k[0];
      @(posedge clk); #1;
      chk("stall_valid", int'(out_valid), 1);
      chk("stall_hold_tanh", int'($signed(tanh)), t0);
      chk("stall_hold_clip", int'(clip), c0);
      chk("stall_in_ready", int'(in_ready), 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_out_valid", int'(out_valid), 0);
    chk("release_in_ready", int'(in_ready), 1);
    seen = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("ignored_inputs", seen, 0);

    // reset during the i=5 rotation aborts silently
    in = 16'h0100; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_in_ready", int'(in_ready), 1);
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_tanh", int'(tanh), 0);
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("abort_no_result", seen, 0);

    run(16'h0080, t, c, lat);
    chk("post_abort_tanh", t, tp5); chk("post_abort_lat", lat, 19);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
